// File: rtl/ball_mover.sv
// ball_mover
//
// Moves a ball around a bounded grid in response to four push buttons. Each
// button produces move events on its rising edge and, while it is held, as
// auto-repeat events. One event at a time is turned into a single-step
// candidate position. The candidate is checked against the grid edges and
// then sent to an external wall lookup over a simple req/ack handshake. The
// ball moves only if the lookup reports a free cell.
//
// Optional feature:
//   BALL_WRAP_EN  when defined, stepping past an edge wraps to the opposite
//                 edge. The wrapped cell is still wall-queried. When the
//                 macro is undefined, stepping past an edge is refused with a
//                 collision pulse and no query is made.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   reset          synchronous, active-high reset
//   x_increment    debounced button level, move +1 in x
//   x_decrement    debounced button level, move -1 in x
//   y_increment    debounced button level, move +1 in y
//   y_decrement    debounced button level, move -1 in y
//   wall_req       wall query request, held until wall_ack
//   wall_x         candidate x under query
//   wall_y         candidate y under query
//   wall_ack       wall query done
//   wall_blocked   candidate is a wall, valid with wall_ack
//   x_out          current x position
//   y_out          current y position
//   moved          one-cycle pulse when the position changes
//   collision      one-cycle pulse when a move is refused
//   busy           high while a wall query is outstanding

module ball_mover #(
    parameter int X_WIDTH      = 4,
    parameter int Y_WIDTH      = 4,
    parameter int X_MAX        = 15,
    parameter int Y_MAX        = 15,
    parameter int X_INIT       = 0,
    parameter int Y_INIT       = 0,
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x_increment,
    input  logic               x_decrement,
    input  logic               y_increment,
    input  logic               y_decrement,
    output logic               wall_req,
    output logic [X_WIDTH-1:0] wall_x,
    output logic [Y_WIDTH-1:0] wall_y,
    input  logic               wall_ack,
    input  logic               wall_blocked,
    output logic [X_WIDTH-1:0] x_out,
    output logic [Y_WIDTH-1:0] y_out,
    output logic               moved,
    output logic               collision,
    output logic               busy
);

    // The hold counter has to reach REPEAT_DELAY exactly. The rate counter
    // runs from 0 to REPEAT_RATE-1. Both widths are kept at least one bit.
    localparam int HOLD_W = (REPEAT_DELAY < 1) ? 1 : $clog2(REPEAT_DELAY + 1);
    localparam int RATE_W = (REPEAT_RATE < 2) ? 1 : $clog2(REPEAT_RATE + 1);

    localparam logic [HOLD_W-1:0]  HOLD_LIMIT = HOLD_W'(REPEAT_DELAY);
    localparam logic [RATE_W-1:0]  RATE_LAST  = RATE_W'(REPEAT_RATE - 1);
    localparam logic [X_WIDTH-1:0] X_MAX_V    = X_WIDTH'(X_MAX);
    localparam logic [Y_WIDTH-1:0] Y_MAX_V    = Y_WIDTH'(Y_MAX);
    localparam logic [X_WIDTH-1:0] X_INIT_V   = X_WIDTH'(X_INIT);
    localparam logic [Y_WIDTH-1:0] Y_INIT_V   = Y_WIDTH'(Y_INIT);

    // Button bit positions. Lower index means higher priority.
    localparam int BTN_XI = 0;
    localparam int BTN_XD = 1;
    localparam int BTN_YI = 2;
    localparam int BTN_YD = 3;

    typedef enum logic {
        IDLE,
        QUERY
    } state_t;

    state_t state;
    state_t next_state;

    logic [3:0]         buttons;
    logic [3:0]         prev_level;
    logic [HOLD_W-1:0]  hold_cnt [4];
    logic [RATE_W-1:0]  rate_cnt [4];
    logic [3:0]         repeat_tick;
    logic [3:0]         raw_event;
    logic [3:0]         events;
    logic               x_conflict;
    logic               y_conflict;
    logic               have_event;

    logic [X_WIDTH-1:0] x_pos;
    logic [Y_WIDTH-1:0] y_pos;
    logic [X_WIDTH-1:0] cand_x;
    logic [Y_WIDTH-1:0] cand_y;
    logic               off_edge;

    logic [X_WIDTH-1:0] next_x_pos;
    logic [Y_WIDTH-1:0] next_y_pos;
    logic [X_WIDTH-1:0] next_wall_x;
    logic [Y_WIDTH-1:0] next_wall_y;
    logic               next_moved;
    logic               next_collision;

    assign buttons = {y_decrement, y_increment, x_decrement, x_increment};

    // Per-button hold tracking. hold_cnt counts held cycles and stops at
    // REPEAT_DELAY. From then on rate_cnt cycles through REPEAT_RATE values,
    // and each return to zero is one repeat. A release clears both counters,
    // so every new press starts the delay again. The counters keep running
    // while the FSM is busy. Only the resulting events are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_level <= '0;
            for (int i = 0; i < 4; i++) begin
                hold_cnt[i] <= '0;
                rate_cnt[i] <= '0;
            end
        end else begin
            prev_level <= buttons;
            for (int i = 0; i < 4; i++) begin
                if (!buttons[i]) begin
                    hold_cnt[i] <= '0;
                    rate_cnt[i] <= '0;
                end else if (hold_cnt[i] != HOLD_LIMIT) begin
                    hold_cnt[i] <= hold_cnt[i] + 1'b1;
                    rate_cnt[i] <= '0;
                end else if (rate_cnt[i] == RATE_LAST) begin
                    rate_cnt[i] <= '0;
                end else begin
                    rate_cnt[i] <= rate_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A button fires on its rising edge or on a repeat tick. When both
    // buttons of one axis are pressed the intent is ambiguous, so that axis
    // is silenced.
    always_comb begin
        repeat_tick = '0;
        raw_event   = '0;
        for (int i = 0; i < 4; i++) begin
            repeat_tick[i] = (hold_cnt[i] == HOLD_LIMIT) && (rate_cnt[i] == '0);
            raw_event[i]   = buttons[i] && (!prev_level[i] || repeat_tick[i]);
        end
        x_conflict = buttons[BTN_XI] && buttons[BTN_XD];
        y_conflict = buttons[BTN_YI] && buttons[BTN_YD];
        events     = raw_event & ~{y_conflict, y_conflict, x_conflict, x_conflict};
        have_event = |events;
    end

    // Fixed-priority pick of one event and the single-step candidate for it.
    // The axis that does not move keeps its current value. off_edge marks a
    // step that would leave the grid. It can only be set when wrapping is
    // disabled.
    always_comb begin
        cand_x   = x_pos;
        cand_y   = y_pos;
        off_edge = 1'b0;
        if (events[BTN_XI]) begin
            if (x_pos == X_MAX_V) begin
`ifdef BALL_WRAP_EN
                cand_x = '0;
`else
                off_edge = 1'b1;
`endif
            end else begin
                cand_x = x_pos + 1'b1;
            end
        end else if (events[BTN_XD]) begin
            if (x_pos == '0) begin
`ifdef BALL_WRAP_EN
                cand_x = X_MAX_V;
`else
                off_edge = 1'b1;
`endif
            end else begin
                cand_x = x_pos - 1'b1;
            end
        end else if (events[BTN_YI]) begin
            if (y_pos == Y_MAX_V) begin
`ifdef BALL_WRAP_EN
                cand_y = '0;
`else
                off_edge = 1'b1;
`endif
            end else begin
                cand_y = y_pos + 1'b1;
            end
        end else if (events[BTN_YD]) begin
            if (y_pos == '0) begin
`ifdef BALL_WRAP_EN
                cand_y = Y_MAX_V;
`else
                off_edge = 1'b1;
`endif
            end else begin
                cand_y = y_pos - 1'b1;
            end
        end
    end

    // State and datapath registers. Reset wins in every state, including an
    // outstanding query. The wall interface simply sees wall_req drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            x_pos     <= X_INIT_V;
            y_pos     <= Y_INIT_V;
            wall_x    <= X_INIT_V;
            wall_y    <= Y_INIT_V;
            moved     <= 1'b0;
            collision <= 1'b0;
        end else begin
            state     <= next_state;
            x_pos     <= next_x_pos;
            y_pos     <= next_y_pos;
            wall_x    <= next_wall_x;
            wall_y    <= next_wall_y;
            moved     <= next_moved;
            collision <= next_collision;
        end
    end

    // IDLE turns an event into a query, or into an immediate collision when
    // the step would leave the grid. QUERY holds the candidate on wall_x/
    // wall_y until the acknowledge arrives. The candidate is then either
    // committed with a moved pulse or refused with a collision pulse. The
    // two pulses come from exclusive branches, so they are never high
    // together.
    always_comb begin
        next_state     = state;
        next_x_pos     = x_pos;
        next_y_pos     = y_pos;
        next_wall_x    = wall_x;
        next_wall_y    = wall_y;
        next_moved     = 1'b0;
        next_collision = 1'b0;
        case (state)
            IDLE: begin
                if (have_event) begin
                    if (off_edge) begin
                        next_collision = 1'b1;
                    end else begin
                        next_wall_x = cand_x;
                        next_wall_y = cand_y;
                        next_state  = QUERY;
                    end
                end
            end
            QUERY: begin
                if (wall_ack) begin
                    next_state = IDLE;
                    if (wall_blocked) begin
                        next_collision = 1'b1;
                    end else begin
                        next_x_pos = wall_x;
                        next_y_pos = wall_y;
                        next_moved = 1'b1;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign wall_req = (state == QUERY);
    assign busy     = (state != IDLE);
    assign x_out    = x_pos;
    assign y_out    = y_pos;

endmodule

// File: tb/tb_ball_mover.sv
// Testbench for ball_mover. A small grid is used (4-bit axes, start at (0,4))
// together with short repeat timing so auto-repeat fits in a few dozen
// cycles. A responder process acts as the wall lookup. Every expected
// moved/collision pulse is queued when its stimulus is driven. A monitor
// then pops the entry and checks it when the pulse appears.

module tb_ball_mover;

    localparam int XW = 4;
    localparam int YW = 4;
    localparam int XM = 15;
    localparam int YM = 15;
    localparam int XI = 0;
    localparam int YI = 4;
    localparam int RD = 20;
    localparam int RR = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          xi, xd, yi, yd;
    logic          wall_req;
    logic [XW-1:0] wall_x;
    logic [YW-1:0] wall_y;
    logic          wall_ack;
    logic          wall_blocked;
    logic [XW-1:0] x_out;
    logic [YW-1:0] y_out;
    logic          moved;
    logic          collision;
    logic          busy;

    ball_mover #(
        .X_WIDTH(XW), .Y_WIDTH(YW), .X_MAX(XM), .Y_MAX(YM),
        .X_INIT(XI), .Y_INIT(YI), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .reset(reset),
        .x_increment(xi), .x_decrement(xd),
        .y_increment(yi), .y_decrement(yd),
        .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y),
        .wall_ack(wall_ack), .wall_blocked(wall_blocked),
        .x_out(x_out), .y_out(y_out),
        .moved(moved), .collision(collision), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_collision;
        int x;
        int y;
        int at;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // Wall responder configuration and bookkeeping.
    int   ack_at = 1;
    bit   blocked_cfg = 1'b0;
    bit   idle_ack = 1'b0;
    int   req_run = 0;
    int   last_run = 0;
    int   query_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // The wall lookup acknowledges in the ack_at-th cycle of each request.
    always @(negedge clk) begin
        if (wall_req) begin
            if (req_run == 0) query_count++;
            req_run++;
            wall_ack     = (req_run == ack_at);
            wall_blocked = blocked_cfg;
        end else begin
            if (req_run != 0) last_run = req_run;
            req_run      = 0;
            wall_ack     = idle_ack;
            wall_blocked = 1'b0;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (moved || collision) begin
            checkOutput("pulse_exclusive", {31'd0, moved & collision}, 32'd0);
            checkOutput("pulse_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("sb_collision", {31'd0, collision}, {31'd0, e.is_collision});
                checkOutput("sb_x", {28'd0, x_out}, e.x);
                checkOutput("sb_y", {28'd0, y_out}, e.y);
                if (e.at >= 0) checkOutput("sb_cycle", cyc, e.at);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] btns, input int hold);
        {yd, yi, xd, xi} = btns;
        tick(hold);
        {yd, yi, xd, xi} = 4'b0000;
    endtask

    task automatic expectEvent(input bit coll, input int x, input int y, input int at);
        exp_t e;
        e.is_collision = coll;
        e.x = x;
        e.y = y;
        e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic doReset(input int n);
        reset = 1'b1;
        tick(n);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c0;
        int q0;
        int ks[10];
        reset = 1'b1;
        {yd, yi, xd, xi} = 4'b0000;
        wall_ack = 1'b0;
        wall_blocked = 1'b0;
        tick(3);

        // Reset state.
        checkOutput("rst_x_out", x_out, XI);
        checkOutput("rst_y_out", y_out, YI);
        checkOutput("rst_wall_x", wall_x, XI);
        checkOutput("rst_wall_y", wall_y, YI);
        checkOutput("rst_wall_req", wall_req, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_moved", moved, 0);
        checkOutput("rst_collision", collision, 0);
        reset = 1'b0;
        tick(2);

        // Single press with immediate ack: move lands two cycles after the event.
        $display("[TB] single step with immediate ack");
        expectEvent(0, 1, 4, cyc + 2);
        applyStimulus(4'b0001, 1);
        checkOutput("q_wall_req", wall_req, 1);
        checkOutput("q_wall_x", wall_x, 1);
        checkOutput("q_wall_y", wall_y, 4);
        checkOutput("q_busy", busy, 1);
        checkOutput("q_x_out_old", x_out, 0);
        tick(1);
        checkOutput("step_x_out", x_out, 1);
        checkOutput("step_moved", moved, 1);
        tick(3);

        // Bring x to 3, then a blocked y step with a slow ack.
        for (int i = 0; i < 2; i++) begin
            expectEvent(0, 2 + i, 4, -1);
            applyStimulus(4'b0001, 1);
            tick(3);
        end
        $display("[TB] blocked step with slow ack");
        ack_at = 5;
        blocked_cfg = 1'b1;
        expectEvent(1, 3, 4, cyc + 6);
        applyStimulus(4'b1000, 1);
        checkOutput("blk_wall_req", wall_req, 1);
        checkOutput("blk_wall_y", wall_y, 3);
        tick(6);
        checkOutput("blk_req_cycles", last_run, 5);
        checkOutput("blk_y_out", y_out, 4);
        checkOutput("blk_x_out", x_out, 3);
        checkOutput("blk_busy", busy, 0);
        tick(2);
        blocked_cfg = 1'b0;
        ack_at = 1;

        // Auto-repeat: hold 36 cycles -> moves at 0, 20, 25, 30, 35.
        $display("[TB] auto-repeat");
        doReset(2);
        c0 = cyc;
        q0 = query_count;
        expectEvent(0, 1, 4, c0 + 2);
        expectEvent(0, 2, 4, c0 + 22);
        expectEvent(0, 3, 4, c0 + 27);
        expectEvent(0, 4, 4, c0 + 32);
        expectEvent(0, 5, 4, c0 + 37);
        applyStimulus(4'b0001, 36);
        tick(4);
        checkOutput("rep_x_out", x_out, 5);
        checkOutput("rep_queries", query_count - q0, 5);

        // Hold to the upper edge: ten moves to 15, then the edge attempt.
        $display("[TB] upper x edge");
        c0 = cyc;
        q0 = query_count;
        ks = '{0, 20, 25, 30, 35, 40, 45, 50, 55, 60};
        for (int i = 0; i < 10; i++) expectEvent(0, 6 + i, 4, c0 + ks[i] + 2);
`ifdef BALL_WRAP_EN
        expectEvent(0, 0, 4, c0 + 67);
`else
        expectEvent(1, 15, 4, c0 + 66);
`endif
        applyStimulus(4'b0001, 66);
        tick(4);
`ifdef BALL_WRAP_EN
        checkOutput("edge_x_out", x_out, 0);
        checkOutput("edge_wall_x", wall_x, 0);
        checkOutput("edge_queries", query_count - q0, 11);
`else
        checkOutput("edge_x_out", x_out, 15);
        checkOutput("edge_wall_x", wall_x, 15);
        checkOutput("edge_queries", query_count - q0, 10);
`endif

        // Ack while idle is ignored.
        idle_ack = 1'b1;
        tick(4);
        idle_ack = 1'b0;
        tick(1);
`ifdef BALL_WRAP_EN
        checkOutput("idle_ack_x", x_out, 0);
`else
        checkOutput("idle_ack_x", x_out, 15);
`endif
        checkOutput("idle_ack_busy", busy, 0);

        // Both x buttons plus y_increment: only y moves.
        $display("[TB] axis conflict");
        doReset(2);
        expectEvent(0, 0, 5, cyc + 2);
        applyStimulus(4'b0111, 1);
        tick(3);
        checkOutput("conf_x_out", x_out, 0);
        checkOutput("conf_y_out", y_out, 5);

        // Reset during an outstanding query.
        $display("[TB] reset mid-query");
        ack_at = 1000;
        applyStimulus(4'b0100, 1);
        checkOutput("mq_wall_req", wall_req, 1);
        checkOutput("mq_wall_y", wall_y, 6);
        tick(2);
        reset = 1'b1;
        tick(1);
        checkOutput("mq_rst_wall_req", wall_req, 0);
        checkOutput("mq_rst_x_out", x_out, XI);
        checkOutput("mq_rst_y_out", y_out, YI);
        checkOutput("mq_rst_busy", busy, 0);
        reset = 1'b0;
        ack_at = 1;
        tick(2);

        // Button held through reset fires in the first cycle after reset.
        $display("[TB] button held through reset");
        reset = 1'b1;
        xi = 1'b1;
        tick(2);
        reset = 1'b0;
        expectEvent(0, 1, 4, cyc + 2);
        tick(1);
        xi = 1'b0;
        tick(4);
        checkOutput("hold_rst_x_out", x_out, 1);

        // Lower x edge.
        $display("[TB] lower x edge");
        doReset(2);
`ifdef BALL_WRAP_EN
        expectEvent(0, 15, 4, cyc + 2);
`else
        expectEvent(1, 0, 4, cyc + 1);
`endif
        applyStimulus(4'b0010, 1);
        tick(3);
`ifdef BALL_WRAP_EN
        checkOutput("low_x_out", x_out, 15);
`else
        checkOutput("low_x_out", x_out, 0);
`endif

        // Events while busy are discarded.
        $display("[TB] event while busy");
        doReset(2);
        ack_at = 4;
        expectEvent(0, 1, 4, cyc + 5);
        applyStimulus(4'b0001, 1);
        applyStimulus(4'b0100, 1);
        tick(6);
        checkOutput("busy_y_out", y_out, 4);
        checkOutput("busy_x_out", x_out, 1);
        ack_at = 1;

        // Priority: x_increment beats y_increment.
        expectEvent(0, 2, 4, cyc + 2);
        applyStimulus(4'b0101, 1);
        tick(3);
        checkOutput("prio_x_out", x_out, 2);
        checkOutput("prio_y_out", y_out, 4);

        // Free y_decrement step.
        expectEvent(0, 2, 3, cyc + 2);
        applyStimulus(4'b1000, 1);
        tick(3);
        checkOutput("ydec_y_out", y_out, 3);

        tick(3);
        checkOutput("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ball_mover.md
BALL_MOVER -- requirements
Module: ball_mover

Interface
REQ-001 Parameter X_WIDTH, default 4: width of the x position.
REQ-002 Parameter Y_WIDTH, default 4: width of the y position.
REQ-003 Parameter X_MAX, default 15: largest legal x; range 1..2^X_WIDTH-1.
REQ-004 Parameter Y_MAX, default 15: largest legal y; range 1..2^Y_WIDTH-1.
REQ-005 Parameters X_INIT and Y_INIT, default 0: position after reset.
REQ-006 Parameter REPEAT_DELAY, default 50_000_000: cycles a button must be held before auto-repeat starts.
REQ-007 Parameter REPEAT_RATE, default 10_000_000: cycles between auto-repeat events.
REQ-008 clk  in  1  system clock; one clock, all logic on rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 x_increment, x_decrement, y_increment, y_decrement  in  1 each  debounced button levels, active high.
REQ-011 wall_req  out  1  wall-query request, held until acknowledged.
REQ-012 wall_x  out  X_WIDTH  candidate x under query; wall_y  out  Y_WIDTH  candidate y under query.
REQ-013 wall_ack  in  1  query done; wall_blocked  in  1  candidate cell is a wall, valid with wall_ack.
REQ-014 x_out  out  X_WIDTH  current x; y_out  out  Y_WIDTH  current y.
REQ-015 moved  out  1  one-cycle pulse when the position changes.
REQ-016 collision  out  1  one-cycle pulse when a move is refused (wall or edge).
REQ-017 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-018 Each button SHALL generate a move event on its rising edge (registered previous level), at REPEAT_DELAY cycles of continuous hold, then every REPEAT_RATE further cycles while held.
REQ-019 Releasing a button SHALL clear its hold counter; counters SHALL saturate and never wrap.
REQ-020 Events SHALL be arbitrated by fixed priority x_increment > x_decrement > y_increment > y_decrement; one axis step per move.
REQ-021 If both buttons of one axis are high, that axis SHALL produce no events.
REQ-022 Events arriving while busy SHALL be discarded; hold counters keep running.
REQ-023 The FSM SHALL have states IDLE and QUERY.
REQ-024 IDLE with an event: compute candidate (±1 on one axis), register it on wall_x/wall_y, and go to QUERY, so wall_req is high the next cycle.
REQ-025 IDLE with an event that would leave 0..MAX (no wrap): stay IDLE, issue no query, pulse collision next cycle.
REQ-026 QUERY: hold wall_req and the candidate stable until wall_ack is sampled high, then return to IDLE with wall_req low.
REQ-027 On ack with wall_blocked=0, load the candidate into x_out/y_out at that edge and pulse moved the same cycle the new position appears.
REQ-028 On ack with wall_blocked=1, keep the position unchanged and pulse collision.
REQ-029 Minimum latency from an event cycle to the updated position SHALL be 2 cycles, with wall_ack high in the first QUERY cycle.
REQ-030 wall_ack sampled in IDLE SHALL be ignored.
REQ-031 moved and collision SHALL never be high in the same cycle.

Reset
REQ-032 Reset SHALL take effect at the next rising edge regardless of state, including mid-QUERY.
REQ-033 After reset: state IDLE, x_out=X_INIT, y_out=Y_INIT, wall_x=X_INIT, wall_y=Y_INIT, and wall_req, moved, collision, busy all 0.
REQ-034 After reset, hold counters SHALL be 0 and previous-level registers SHALL be 0, so a button held through reset produces a rising-edge event in the first cycle after reset.

Configuration
REQ-035 Macro BALL_WRAP_EN defined: incrementing from MAX SHALL give candidate 0 and decrementing from 0 SHALL give MAX, still wall-queried; REQ-025 does not apply.
REQ-036 Macro BALL_WRAP_EN undefined: edges saturate per REQ-025.

Verification
REQ-037 Reset, then x_increment one cycle, wall_ack=1 with wall_blocked=0 on the first wall_req cycle -> wall_x=1, then x_out=1 and moved pulse exactly 2 cycles after the event.
REQ-038 x_out=3, y_decrement pulse, wall_ack after 5 cycles with wall_blocked=1 -> wall_req high 5 cycles, y_out unchanged, one collision pulse, no moved.
REQ-039 REPEAT_DELAY=20, REPEAT_RATE=5, x_increment held 36 cycles, immediate ack -> 5 moves (press, cycle 20, 25, 30, 35), x_out=5.
REQ-040 x_out=X_MAX=15, x_increment; without BALL_WRAP_EN -> no wall_req, collision pulse, x_out=15; with BALL_WRAP_EN -> query at wall_x=0, x_out=0.
REQ-041 x_increment and x_decrement high together with y_increment -> only y moves; reset asserted during QUERY -> next cycle wall_req=0 and position=(X_INIT,Y_INIT).
